data_mem_responder: RTL and testbench
=====================================

# data_mem_responder

Responder end of the core's data-memory interface. It accepts load and store requests from the pipeline's MEM stage and executes them against an internal byte-banked synchronous RAM with a configurable number of wait states. It merges sub-word stores, sign- or zero-extends sub-word loads, and holds the pipeline through a stall output until each access completes.

## Interface
- `ADDR_WIDTH`, 10: word-address width; RAM depth is 2^ADDR_WIDTH words of 32 bits.
- `WAIT_STATES`, 1: extra cycles inserted before the RAM access; legal range 0-15.

- `clk` input 1: clock, rising-edge.
- `rst` input 1: reset, asynchronous, active-high.
- `req_i` input 1: access request; initiator holds it and all request fields stable until `ready_o`.
- `we_i` input 1: 1 = store, 0 = load.
- `funct3_i` input 3: access size and sign, RISC-V encoding: 000 B, 001 H, 010 W, 100 BU, 101 HU; other codes are treated as W.
- `addr_i` input 32: byte address.
- `wdata_i` input 32: store data, right-aligned.
- `rdata_o` output 32: load result, extended to 32 bits.
- `ready_o` output 1: one-cycle pulse marking access completion.
- `stall_o` output 1: pipeline hold; feeds the PC and IF/ID enables, inverted.
- `misaligned_o` output 1: pulses with `ready_o` when the access was rejected as misaligned.

## Operation
- FSM states are IDLE, WAIT, ACCESS and RESP.
- **IDLE, `req_i` = 1:** latch the request.
  - If misaligned (H with `addr[0]` = 1, or W with `addr[1:0]` ≠ 0), go to RESP with the misaligned flag set. The access is not performed.
  - Otherwise load the wait counter with `WAIT_STATES`. Go to WAIT, or to ACCESS if `WAIT_STATES` = 0.
- **WAIT:** decrement the counter; go to ACCESS when the counter reaches 1.
- **ACCESS:** on the clock edge, either:
  - write the enabled byte banks, or
  - read the word at `addr[ADDR_WIDTH+1:2]` into the read register.
  - Then go to RESP.
- **RESP:** assert `ready_o`, and `misaligned_o` if flagged. Go to IDLE. `req_i` is ignored in this state.
- Address handling:
  - Byte lane = `addr[1:0]`.
  - Upper address bits above `ADDR_WIDTH+1` are ignored, so addresses wrap modulo the RAM size.
- Store byte enables (no read-modify-write):
  - SB writes lane `addr[1:0]` with `wdata_i[7:0]`.
  - SH writes lanes {`addr[1]`,0}/{`addr[1]`,1} with `wdata_i[15:0]`.
  - SW writes all four lanes.
- Loads:
  - B/H select the lane(s) and sign-extend.
  - BU/HU zero-extend.
  - W passes the full word.
- `rdata_o` updates only on load completion. It holds its value across stores and idle cycles, and is 0 after a misaligned load.
- `stall_o` = (IDLE and `req_i`) or WAIT or ACCESS. It is low in RESP, so the pipeline advances on the RESP edge.
- Reset values: `rdata_o` = 0, `ready_o` = 0, `stall_o` = 0, `misaligned_o` = 0, state IDLE.
- RAM contents are not reset.

## Timing
- Latency: with `req_i` first high in cycle 0, `ready_o` is high in cycle `WAIT_STATES`+2. A misaligned access completes in cycle 1.
- Back-to-back: a new request is accepted in the cycle after RESP. The minimum spacing is `WAIT_STATES`+3 cycles.
- The store becomes visible to a load issued after its `ready_o`.
- Reset asserted mid-operation:
  - Immediate return to IDLE; outputs are cleared asynchronously.
  - A store aborted before its ACCESS edge leaves memory unchanged.
- `req_i` deasserted before `ready_o` is a protocol violation; behaviour is unspecified.

## Configuration
- Macro: `DATA_MEM_MISALIGN_CHECK_EN`.
- Defined: misalignment is detected and rejected as described above.
- Undefined:
  - `misaligned_o` is tied to 0.
  - Address bits below the access size are ignored: H uses `addr[1]` only, W forces the lane to 0.
  - Every access executes with full latency.

## Test plan
- Reset then SW 0xDEADBEEF to 0x10, then LW from 0x10 → `ready_o` pulses in cycle 3 for each access (`WAIT_STATES`=1); `rdata_o` = 0xDEADBEEF; `stall_o` high for cycles 0-2 of each access.
- SB 0x80 to 0x11 over word 0x00000000, then LB from 0x11 → 0xFFFFFF80; LBU from 0x11 → 0x00000080; LW from 0x10 → 0x00008000.
- SH 0x1234 to 0x22, then LW from 0x20 → 0x12340000; LH from 0x22 → 0x00001234.
- With the macro defined: LW from 0x13 → `ready_o` and `misaligned_o` pulse in cycle 1, `rdata_o` = 0; an SW to 0x13 leaves word 0x10 unchanged.
- SW 0xFFFFFFFF to 0x30 with `rst` asserted in WAIT → all outputs 0 immediately; a following LW from 0x30 returns the prior contents.
- `WAIT_STATES`=0, four back-to-back LW requests → `ready_o` every 3 cycles; address 0x1000 (with `ADDR_WIDTH`=10) aliases to 0x0.

Source files
------------

// File: rtl/data_mem_responder.sv
// Data-memory responder: serves MEM-stage loads/stores from a byte-banked RAM after WAIT_STATES wait cycles.
// Define DATA_MEM_MISALIGN_CHECK_EN to reject misaligned H/W accesses; otherwise low address bits are ignored.
module data_mem_responder #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        ready_o,
  output logic        stall_o,
  output logic        misaligned_o
);
  localparam int         DEPTH = 1 << ADDR_WIDTH;
  localparam logic [3:0] WS    = 4'(WAIT_STATES);

  typedef enum logic [1:0] {IDLE, WAIT, ACCESS, RESP} state_t;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} acc_size_t;

  state_t     state;
  logic [3:0] wait_cnt;

  logic [7:0] bank [4][DEPTH];

  acc_size_t             req_size;
  logic [1:0]            req_lane;
  logic                  mis_req;
  logic                  we_q;
  acc_size_t             size_q;
  logic                  uns_q;
  logic [1:0]            lane_q;
  logic [ADDR_WIDTH-1:0] widx_q;
  logic [31:0]           wdata_q;
  logic [31:0]           ram_word;
  logic [31:0]           wdata_rep;
  logic [3:0]            byte_en;
  logic                  unused_addr_bits;

  function automatic acc_size_t decode_size(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b100: return SZ_B;
      3'b001, 3'b101: return SZ_H;
      default:        return SZ_W;
    endcase
  endfunction

  // Lane actually used by the access: sub-size address bits are dropped.
  function automatic logic [1:0] eff_lane(input acc_size_t sz, input logic [1:0] a);
    case (sz)
      SZ_B:    return a;
      SZ_H:    return {a[1], 1'b0};
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic [3:0] lane_enables(input acc_size_t sz, input logic [1:0] lane);
    case (sz)
      SZ_B:    return 4'b0001 << lane;
      SZ_H:    return 4'b0011 << lane;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] replicate_store(input acc_size_t sz, input logic [31:0] w);
    case (sz)
      SZ_B:    return {4{w[7:0]}};
      SZ_H:    return {2{w[15:0]}};
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] load_extend(input logic [31:0] w, input acc_size_t sz,
                                              input logic uns, input logic [1:0] lane);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    b = w[{lane, 3'b000} +: 8];
    h = lane[1] ? w[31:16] : w[15:0];
    case (sz)
      SZ_B:    return uns ? {24'd0, b} : 32'(b);
      SZ_H:    return uns ? {16'd0, h} : 32'(h);
      default: return w;
    endcase
  endfunction

  assign req_size         = decode_size(funct3_i);
  assign req_lane         = eff_lane(req_size, addr_i[1:0]);
  assign unused_addr_bits = ^addr_i[31:ADDR_WIDTH+2];

`ifdef DATA_MEM_MISALIGN_CHECK_EN
  assign mis_req = (req_size == SZ_H && addr_i[0]) || (req_size == SZ_W && addr_i[1:0] != 2'b00);
`else
  assign mis_req = 1'b0;
`endif

  assign ram_word  = {bank[3][widx_q], bank[2][widx_q], bank[1][widx_q], bank[0][widx_q]};
  assign wdata_rep = replicate_store(size_q, wdata_q);
  assign byte_en   = lane_enables(size_q, lane_q);

  // Gated by rst so the pipeline hold drops the instant reset is applied.
  assign stall_o = !rst && ((state == IDLE && req_i) || state == WAIT || state == ACCESS);

  // ---- request capture (IDLE -> WAIT/ACCESS boundary)
  always_ff @(posedge clk) begin
    if (state == IDLE && req_i) begin
      we_q    <= we_i;
      size_q  <= req_size;
      uns_q   <= funct3_i[2];
      lane_q  <= req_lane;
      widx_q  <= addr_i[ADDR_WIDTH+1:2];
      wdata_q <= wdata_i;
    end
  end

  // ---- RAM write (ACCESS -> RESP boundary)
  always_ff @(posedge clk) begin
    if (state == ACCESS && we_q) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) bank[b][widx_q] <= wdata_rep[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      wait_cnt     <= 4'd0;
      ready_o      <= 1'b0;
      misaligned_o <= 1'b0;
      rdata_o      <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (req_i) begin
            if (mis_req) begin
              state        <= RESP;
              ready_o      <= 1'b1;
              misaligned_o <= 1'b1;
              if (!we_i) rdata_o <= 32'd0;
            end else if (WS == 4'd0) begin
              state <= ACCESS;
            end else begin
              wait_cnt <= WS;
              state    <= WAIT;
            end
          end
        end
        WAIT: begin
          if (wait_cnt == 4'd1) state <= ACCESS;
          else                  wait_cnt <= wait_cnt - 4'd1;
        end
        ACCESS: begin
          state   <= RESP;
          ready_o <= 1'b1;
          if (!we_q) rdata_o <= load_extend(ram_word, size_q, uns_q, lane_q);
        end
        default: begin
          state        <= IDLE;
          ready_o      <= 1'b0;
          misaligned_o <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: directed table, corner sequences, and random traffic against a byte-array model.
module tb_data_mem_responder;
  localparam int AW        = 10;
  localparam int WS0       = 1;
  localparam int MEM_BYTES = 4 << AW;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_i, we_i;
  logic [2:0]  funct3_i;
  logic [31:0] addr_i, wdata_i, rdata_o;
  logic        ready_o, stall_o, misaligned_o;

  logic        req1, we1;
  logic [2:0]  f31;
  logic [31:0] addr1, wd1, rdata1;
  logic        ready1, stall1, mis1;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  data_mem_responder #(.ADDR_WIDTH(AW), .WAIT_STATES(WS0)) u_dut (
    .clk(clk), .rst(rst), .req_i(req_i), .we_i(we_i), .funct3_i(funct3_i),
    .addr_i(addr_i), .wdata_i(wdata_i), .rdata_o(rdata_o), .ready_o(ready_o),
    .stall_o(stall_o), .misaligned_o(misaligned_o)
  );

  data_mem_responder #(.ADDR_WIDTH(AW), .WAIT_STATES(0)) u_dut0 (
    .clk(clk), .rst(rst), .req_i(req1), .we_i(we1), .funct3_i(f31),
    .addr_i(addr1), .wdata_i(wd1), .rdata_o(rdata1), .ready_o(ready1),
    .stall_o(stall1), .misaligned_o(mis1)
  );

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    string       name;
  } vec_t;

  vec_t tbl [21];

  logic [7:0]  mem_m [MEM_BYTES];
  logic [31:0] rd_m;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", nm, act, exp);
    end
  endtask

  // Byte-addressed reference: sizes, alignment and extension from the access rules.
  task automatic model_acc(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wd, output logic mis, output int lat);
    int nb, a;
    logic [31:0] v;
    nb = (f3 == 3'b000 || f3 == 3'b100) ? 1 : (f3 == 3'b001 || f3 == 3'b101) ? 2 : 4;
    a  = int'(addr[AW+1:0]);
`ifdef DATA_MEM_MISALIGN_CHECK_EN
    mis = (a % nb) != 0;
`else
    mis = 1'b0;
    a   = a - (a % nb);
`endif
    lat = mis ? 1 : WS0 + 2;
    if (mis) begin
      if (!we) rd_m = 32'h0;
    end else if (we) begin
      for (int i = 0; i < nb; i++) mem_m[a+i] = wd[8*i +: 8];
    end else begin
      v = 32'h0;
      for (int i = 0; i < nb; i++) v[8*i +: 8] = mem_m[a+i];
      if (nb < 4 && !f3[2] && v[8*nb-1]) begin
        for (int i = 8*nb; i < 32; i++) v[i] = 1'b1;
      end
      rd_m = v;
    end
  endtask

  // Starts at posedge+1; returns at posedge+1 after the response cycle.
  task automatic run_acc(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_mis,
                         input int exp_lat, input string nm);
    int   lat;
    logic stall_ok, mis_seen;
    we_i = we; funct3_i = f3; addr_i = addr; wdata_i = wd; req_i = 1'b1;
    lat = -1; stall_ok = 1'b1; mis_seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (ready_o) begin
        lat = c;
        mis_seen = misaligned_o;
        if (stall_o) stall_ok = 1'b0;
        break;
      end
      if (!stall_o || misaligned_o) stall_ok = 1'b0;
    end
    chk({nm, " latency"}, lat, exp_lat);
    chk({nm, " stall"}, {31'd0, stall_ok}, 32'd1);
    chk({nm, " misaligned"}, {31'd0, mis_seen}, {31'd0, exp_mis});
    chk({nm, " rdata"}, rdata_o, exp_rd);
    @(posedge clk);
    #1;
    req_i = 1'b0;
    chk({nm, " ready_pulse"}, {31'd0, ready_o}, 32'd0);
  endtask

  task automatic tbl_acc(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_mis,
                         input int exp_lat, input string nm);
    logic mm;
    int   ml;
    model_acc(we, f3, addr, wd, mm, ml);
    run_acc(we, f3, addr, wd, exp_rd, exp_mis, exp_lat, nm);
  endtask

  initial begin
    logic        mm, rwe;
    int          ml, t_start, t_prev, t_rdy;
    logic [2:0]  rf3;
    logic [31:0] raddr, d;

    tbl[0]  = '{1'b1, 3'b010, 32'h10,       32'hDEADBEEF, 32'h00000000, "sw_deadbeef"};
    tbl[1]  = '{1'b0, 3'b010, 32'h10,       32'h0,        32'hDEADBEEF, "lw_deadbeef"};
    tbl[2]  = '{1'b1, 3'b010, 32'h10,       32'h00000000, 32'hDEADBEEF, "sw_zero"};
    tbl[3]  = '{1'b1, 3'b000, 32'h11,       32'hAAAAAA80, 32'hDEADBEEF, "sb_80"};
    tbl[4]  = '{1'b0, 3'b000, 32'h11,       32'h0,        32'hFFFFFF80, "lb_11"};
    tbl[5]  = '{1'b0, 3'b100, 32'h11,       32'h0,        32'h00000080, "lbu_11"};
    tbl[6]  = '{1'b0, 3'b010, 32'h10,       32'h0,        32'h00008000, "lw_after_sb"};
    tbl[7]  = '{1'b1, 3'b010, 32'h20,       32'h00000000, 32'h00008000, "sw_zero_20"};
    tbl[8]  = '{1'b1, 3'b001, 32'h22,       32'h55551234, 32'h00008000, "sh_1234"};
    tbl[9]  = '{1'b0, 3'b010, 32'h20,       32'h0,        32'h12340000, "lw_after_sh"};
    tbl[10] = '{1'b0, 3'b001, 32'h22,       32'h0,        32'h00001234, "lh_22"};
    tbl[11] = '{1'b1, 3'b010, 32'h24,       32'h89ABCDEF, 32'h00001234, "sw_89ab"};
    tbl[12] = '{1'b0, 3'b001, 32'h26,       32'h0,        32'hFFFF89AB, "lh_26"};
    tbl[13] = '{1'b0, 3'b101, 32'h24,       32'h0,        32'h0000CDEF, "lhu_24"};
    tbl[14] = '{1'b0, 3'b000, 32'h27,       32'h0,        32'hFFFFFF89, "lb_27"};
    tbl[15] = '{1'b0, 3'b100, 32'h25,       32'h0,        32'h000000CD, "lbu_25"};
    tbl[16] = '{1'b0, 3'b011, 32'h24,       32'h0,        32'h89ABCDEF, "l_f3_011"};
    tbl[17] = '{1'b0, 3'b010, 32'h1010,     32'h0,        32'h00008000, "lw_alias"};
    tbl[18] = '{1'b1, 3'b010, 32'h30,       32'h11223344, 32'h00008000, "sw_30"};
    tbl[19] = '{1'b1, 3'b000, 32'hFFFFF023, 32'h0000005A, 32'h00008000, "sb_alias"};
    tbl[20] = '{1'b0, 3'b010, 32'h20,       32'h0,        32'h5A340000, "lw_after_sb_alias"};

    rst = 1'b1; req_i = 1'b1; we_i = 1'b0; funct3_i = 3'b010; addr_i = 32'h0; wdata_i = 32'h0;
    req1 = 1'b0; we1 = 1'b0; f31 = 3'b010; addr1 = 32'h0; wd1 = 32'h0;
    rd_m = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset rdata", rdata_o, 32'h0);
    chk("reset ready", {31'd0, ready_o}, 32'd0);
    chk("reset stall", {31'd0, stall_o}, 32'd0);
    chk("reset misaligned", {31'd0, misaligned_o}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    req_i = 1'b0;

    for (int i = 0; i < 21; i++) begin
      tbl_acc(tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wd, tbl[i].exp_rd, 1'b0, WS0 + 2, tbl[i].name);
    end

`ifdef DATA_MEM_MISALIGN_CHECK_EN
    tbl_acc(1'b0, 3'b010, 32'h13, 32'h0,        32'h00000000, 1'b1, 1,       "lw_misaligned");
    tbl_acc(1'b1, 3'b010, 32'h13, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1,       "sw_misaligned");
    tbl_acc(1'b0, 3'b010, 32'h10, 32'h0,        32'h00008000, 1'b0, WS0 + 2, "lw_after_sw_mis");
`else
    tbl_acc(1'b0, 3'b010, 32'h13, 32'h0,        32'h00008000, 1'b0, WS0 + 2, "lw_unaligned");
    tbl_acc(1'b0, 3'b001, 32'h23, 32'h0,        32'h00005A34, 1'b0, WS0 + 2, "lh_unaligned");
`endif

    // Reset while a store sits in WAIT: outputs clear at once and memory is untouched.
    we_i = 1'b1; funct3_i = 3'b010; addr_i = 32'h30; wdata_i = 32'hFFFFFFFF; req_i = 1'b1;
    @(posedge clk);
    #1;
    chk("abort stall_before", {31'd0, stall_o}, 32'd1);
    rst = 1'b1;
    req_i = 1'b0;
    #1;
    chk("abort ready", {31'd0, ready_o}, 32'd0);
    chk("abort stall", {31'd0, stall_o}, 32'd0);
    chk("abort misaligned", {31'd0, misaligned_o}, 32'd0);
    chk("abort rdata", rdata_o, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    rd_m = 32'h0;
    tbl_acc(1'b0, 3'b010, 32'h30, 32'h0, 32'h11223344, 1'b0, WS0 + 2, "lw_after_abort");

    for (int w = 0; w < 16; w++) begin
      d = $urandom;
      model_acc(1'b1, 3'b010, 32'(w * 4), d, mm, ml);
      run_acc(1'b1, 3'b010, 32'(w * 4), d, rd_m, mm, ml, "init");
    end
    for (int n = 0; n < 80; n++) begin
      rwe   = 1'($urandom_range(0, 1));
      rf3   = 3'($urandom_range(0, 7));
      raddr = ($urandom & 32'hFFFFF000) | 32'($urandom_range(0, 63));
      d     = $urandom;
      model_acc(rwe, rf3, raddr, d, mm, ml);
      run_acc(rwe, rf3, raddr, d, rd_m, mm, ml, "rnd");
    end

    // Zero-wait-state instance: one store then back-to-back aliased loads.
    t_start = cyc;
    t_prev  = cyc;
    req1 = 1'b1; we1 = 1'b1; f31 = 3'b010; addr1 = 32'h1000; wd1 = 32'hCAFEF00D;
    for (int n = 0; n < 5; n++) begin
      t_rdy = -1;
      for (int c = 0; c < 20; c++) begin
        @(negedge clk);
        if (ready1) begin
          t_rdy = cyc;
          break;
        end
      end
      if (n == 0) begin
        chk("b2b sw_latency", t_rdy - t_start, 32'd2);
      end else begin
        chk("b2b lw_rdata", rdata1, 32'hCAFEF00D);
        chk("b2b spacing", t_rdy - t_prev, 32'd3);
      end
      t_prev = t_rdy;
      @(posedge clk);
      #1;
      if (n < 4) begin
        we1   = 1'b0;
        addr1 = (n % 2 == 0) ? 32'h0 : 32'h1000;
      end else begin
        req1 = 1'b0;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
